fec_encoder: RTL and testbench
==============================

FEC_ENCODER -- requirements
Module: fec_encoder

Interface
REQ-001 The module SHALL have the port clk (input, 1 bit): rising-edge clock for all state.
REQ-002 The module SHALL have the port reset (input, 1 bit): asynchronous, active-low reset.
REQ-003 The module SHALL have the port input_data (input, 1 bit): serial randomized bit from the upstream stage.
REQ-004 The module SHALL have the port data_valid (input, 1 bit): input_data is valid this cycle.
REQ-005 The module SHALL have the port ready_out (output, 1 bit): encoder can accept a bit; an input bit transfers when data_valid && ready_out.
REQ-006 The module SHALL have the port ready_in (input, 1 bit): the downstream interleaver can accept a bit.
REQ-007 The module SHALL have the port output_data (output, 1 bit): serial coded bit.
REQ-008 The module SHALL have the port valid_out (output, 1 bit): output_data is valid; an output bit transfers when valid_out && ready_in.

Function
REQ-009 The block SHALL encode with a rate-1/2, K=7, tail-biting convolutional code: 96 info bits in, 192 coded bits out per block.
REQ-010 Generators SHALL be G1=171 octal, giving X = u^s1^s2^s3^s6, and G2=133 octal, giving Y = u^s2^s3^s5^s6. s1 is the most recent previous bit.
REQ-011 Input SHALL be written into a ping-pong buffer of two 96-bit register banks, with a write index 0..95 and a write-bank select.
REQ-012 After bit 95 of a bank is accepted: mark that bank full, toggle the write bank, and reset the write index to 0.
REQ-013 ready_out SHALL be 0 when the current write bank is full, and 1 otherwise.
REQ-014 The read FSM SHALL have the states IDLE, LOAD and ENCODE.
REQ-015 IDLE -> LOAD when the read bank is full. LOAD SHALL preload the shift register: s1..s6 = bits 95..90 of the read bank, which gives the tail-biting start state.
REQ-016 LOAD -> ENCODE after one cycle.
REQ-017 ENCODE SHALL emit bits in index order 0..95, X before Y for each bit.
REQ-018 Each output transfer SHALL toggle the X/Y phase. After Y, the shift register shifts in u and the read index increments.
REQ-019 After the Y of bit 95 transfers: clear the read bank's full flag and toggle the read bank. If the new read bank is full, go to LOAD; otherwise go to IDLE.
REQ-020 valid_out SHALL be 1 only in ENCODE.
REQ-021 output_data and valid_out SHALL hold stable while ready_in=0.
REQ-022 Latency: when bit 95 is accepted in cycle t into an idle encoder, LOAD SHALL occur at t+1 and the first valid_out SHALL occur at t+2.
REQ-023 Simultaneous events: a write filling one bank and a read releasing the other bank in the same cycle SHALL both take effect; neither flag update is lost.
REQ-024 Throughput: with ready_in=1 continuously, the block SHALL sustain one input bit per two cycles with no ready_out gaps after the first block.
REQ-025 The counters SHALL be 7 bits wide for the index and 1 bit for the phase. The index SHALL never exceed 95 and SHALL wrap to 0.

Reset
REQ-026 On reset low, regardless of the current phase, the block SHALL set: FSM=IDLE, both full flags=0, write and read indices=0, bank selects=0, phase=X, shift register=0.
REQ-027 On reset low, the outputs SHALL be valid_out=0 and output_data=0, with ready_out=1 one cycle after reset deasserts.
REQ-028 Reset mid-block SHALL discard all partial and full blocks; no residual output SHALL follow.

Structure
REQ-029 Package wimax_pkg SHALL hold BLOCK_BITS=96, CODED_BITS=192, G1=7'o171, G2=7'o133, and the enc_state_t typedef (IDLE, LOAD, ENCODE).
REQ-030 One sub-module, fec_pingpong_buf, SHALL hold the two banks, full flags, write indexing and read-bank selection. The encoder FSM and shift register SHALL live in fec_encoder.

Verification
REQ-031 All-zero 96-bit block, ready_in=1: the bench SHALL check 192 zero output bits and valid_out high for 192 consecutive cycles starting at t+2.
REQ-032 Block with bit0=1 and all others 0: the bench SHALL check the first 14 outputs are 1,1,1,0,1,1,1,1,0,0,0,1,1,1, followed by 178 zeros.
REQ-033 Block with bits 90..95=1 and all others 0 (tail-biting check): the bench SHALL compare against a reference model whose start state is 111111; the end state after bit 95 SHALL equal the start state.
REQ-034 Three back-to-back blocks at one bit per two cycles: the bench SHALL check 576 output bits matching the model, ready_out never low after block 1, and correct bank alternation.
REQ-035 Random ready_in toggling (50%): the bench SHALL check output_data stable while stalled and that ready_out drops when both banks are full; the bench SHALL check no bit is lost or duplicated.
REQ-036 Reset asserted at input bit 40 of block 2 while block 1 is encoding: the bench SHALL check valid_out=0 immediately and that a fresh block after reset encodes correctly.

Source files
------------

// File: rtl/wimax_pkg.sv
// Shared constants and types for the rate-1/2 K=7 tail-biting convolutional encoder.
// Also provides the generator tap helper used by the encoder datapath.
package wimax_pkg;

    localparam int BLOCK_BITS = 96;
    localparam int CODED_BITS = 192;
    localparam int IDX_W      = 7;

    localparam logic [6:0] G1 = 7'o171;
    localparam logic [6:0] G2 = 7'o133;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ENCODE = 2'd2
    } enc_state_t;

    // Window layout is {u, s1, s2, s3, s4, s5, s6}, so the octal generator applies directly.
    function automatic logic conv_bit(input logic [6:0] win, input logic [6:0] gen);
        return ^(win & gen);
    endfunction

endpackage

// File: rtl/fec_pingpong_buf.sv
// Two-bank ping-pong store for 96-bit info blocks: serial write side, whole-bank read side.
// Tracks per-bank full flags so the writer and the encoder can work on opposite banks.
module fec_pingpong_buf
    import wimax_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic                  i_wr_bit,
    input  logic                  i_rd_release,
    output logic                  o_wr_ready,
    output logic                  o_rd_avail,
    output logic                  o_next_avail,
    output logic [BLOCK_BITS-1:0] o_rd_bank
);

    logic [BLOCK_BITS-1:0] r_bank [2];
    logic [1:0]            r_full;
    logic [IDX_W-1:0]      r_wr_idx;
    logic                  r_wr_sel;
    logic                  r_rd_sel;

    logic                  w_wr_last;
    logic [1:0]            w_set;
    logic [1:0]            w_clr;

    assign w_wr_last = i_wr_en && (r_wr_idx == IDX_W'(BLOCK_BITS - 1));

    // Set and clear masks are kept separate so a fill and a release in one cycle both land.
    always_comb begin
        w_set = 2'b00;
        w_clr = 2'b00;
        if (w_wr_last)
            w_set[r_wr_sel] = 1'b1;
        if (i_rd_release)
            w_clr[r_rd_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full   <= 2'b00;
            r_wr_idx <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
        end else begin
            r_full <= (r_full & ~w_clr) | w_set;
            if (i_wr_en) begin
                if (w_wr_last) begin
                    r_wr_idx <= '0;
                    r_wr_sel <= ~r_wr_sel;
                end else begin
                    r_wr_idx <= r_wr_idx + IDX_W'(1);
                end
            end
            if (i_rd_release)
                r_rd_sel <= ~r_rd_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_bank[r_wr_sel][r_wr_idx] <= i_wr_bit;
    end

    assign o_wr_ready   = ~r_full[r_wr_sel];
    // A bank completing this cycle counts as available so the encoder can start one cycle earlier.
    assign o_rd_avail   = r_full[r_rd_sel] | w_set[r_rd_sel];
    assign o_next_avail = r_full[~r_rd_sel] | w_set[~r_rd_sel];
    assign o_rd_bank    = r_bank[r_rd_sel];

endmodule

// File: rtl/fec_encoder.sv
// Rate-1/2 K=7 tail-biting convolutional encoder: buffers 96-bit blocks and emits X,Y per info bit.
// The shift register is preloaded from the block tail so the start and end states coincide.
module fec_encoder
    import wimax_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic input_data,
    input  logic data_valid,
    output logic ready_out,
    input  logic ready_in,
    output logic output_data,
    output logic valid_out
);

    enc_state_t            r_state;
    enc_state_t            w_next;
    logic [5:0]            r_sr;
    logic [IDX_W-1:0]      r_rd_idx;
    logic                  r_phase;

    logic                  w_wr_en;
    logic                  w_rd_avail;
    logic                  w_next_avail;
    logic [BLOCK_BITS-1:0] w_rd_bank;
    logic                  w_u;
    logic [6:0]            w_win;
    logic                  w_xfer;
    logic                  w_last;

    assign w_wr_en = data_valid & ready_out;

    fec_pingpong_buf u_buf (
        .clk          (clk),
        .reset        (reset),
        .i_wr_en      (w_wr_en),
        .i_wr_bit     (input_data),
        .i_rd_release (w_last),
        .o_wr_ready   (ready_out),
        .o_rd_avail   (w_rd_avail),
        .o_next_avail (w_next_avail),
        .o_rd_bank    (w_rd_bank)
    );

    // r_sr[5] is s1 (most recent bit), r_sr[0] is s6.
    assign w_u    = w_rd_bank[r_rd_idx];
    assign w_win  = {w_u, r_sr};
    assign w_xfer = (r_state == ENCODE) && ready_in;
    assign w_last = w_xfer && r_phase && (r_rd_idx == IDX_W'(BLOCK_BITS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        valid_out   = 1'b0;
        output_data = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rd_avail)
                    w_next = LOAD;
            end
            LOAD: begin
                w_next = ENCODE;
            end
            ENCODE: begin
                valid_out   = 1'b1;
                output_data = r_phase ? conv_bit(w_win, G2) : conv_bit(w_win, G1);
                if (w_last)
                    w_next = w_next_avail ? LOAD : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state, so they hold naturally while ready_in is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr     <= '0;
            r_rd_idx <= '0;
            r_phase  <= 1'b0;
        end else if (r_state == LOAD) begin
            r_sr     <= w_rd_bank[BLOCK_BITS-1 -: 6];
            r_rd_idx <= '0;
            r_phase  <= 1'b0;
        end else if (w_xfer) begin
            if (!r_phase) begin
                r_phase <= 1'b1;
            end else begin
                r_phase  <= 1'b0;
                r_sr     <= {w_u, r_sr[5:1]};
                r_rd_idx <= w_last ? '0 : r_rd_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fec_encoder.sv
// Scoreboarded bench for fec_encoder: expected coded bits are queued at stimulus time
// from a modular-index reference model, and a negedge monitor pops and compares.
module tb_fec_encoder;
    import wimax_pkg::*;

    logic clk;
    logic reset;
    logic input_data;
    logic data_valid;
    logic ready_out;
    logic ready_in;
    logic output_data;
    logic valid_out;

    fec_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .input_data  (input_data),
        .data_valid  (data_valid),
        .ready_out   (ready_out),
        .ready_in    (ready_in),
        .output_data (output_data),
        .valid_out   (valid_out)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    int   ro_gaps = 0;
    bit   track_ro = 0;
    bit   seen_ro_low = 0;
    bit   rand_rdy = 0;
    int   blocks_sent = 0;
    logic exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_in = rand_rdy ? logic'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: coded pair for bit i uses s_k = blk[(i-k) mod 96], i.e. the block viewed as a ring.
    task automatic push_model(input logic [BLOCK_BITS-1:0] blk);
        logic [6:0] win;
        for (int i = 0; i < BLOCK_BITS; i++) begin
            win[6] = blk[i];
            for (int k = 1; k <= 6; k++)
                win[6-k] = blk[(i - k + BLOCK_BITS) % BLOCK_BITS];
            exp_q.push_back(^(win & G1));
            exp_q.push_back(^(win & G2));
        end
    endtask

    task automatic send_bit(input logic b);
        int waitc = 0;
        data_valid = 1'b1;
        input_data = b;
        forever begin
            @(negedge clk);
            if (ready_out) break;
            if (track_ro) ro_gaps++;
            waitc++;
            if (waitc > 5000) begin
                chk("ready_out_timeout", 32'(ready_out), 32'd1);
                break;
            end
        end
        last_acc_cyc = cyc;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic send_block(input logic [BLOCK_BITS-1:0] blk, input int gap);
        for (int i = 0; i < BLOCK_BITS; i++) begin
            send_bit(blk[i]);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        blocks_sent++;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_drain", 32'(valid_out), 32'd0);
    endtask

    function automatic logic [BLOCK_BITS-1:0] rand_block();
        logic [BLOCK_BITS-1:0] b;
        for (int i = 0; i < BLOCK_BITS; i += 32)
            b[i +: 32] = $urandom;
        return b;
    endfunction

    // Monitor: compares each transferred output against the queue and checks hold-while-stalled.
    initial begin
        logic prev_stall;
        logic prev_data;
        logic e;
        prev_stall = 1'b0;
        prev_data  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid_hold", 32'(valid_out), 32'd1);
                    chk("stall_data_hold", 32'(output_data), 32'(prev_data));
                end
                if (valid_out && ready_in) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_output", 32'(valid_out), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("coded_bit", 32'(output_data), 32'(e));
                    end
                end
                prev_stall = valid_out && !ready_in;
                prev_data  = output_data;
                if (!ready_out) seen_ro_low = 1'b1;
            end
        end
    end

    initial begin
        logic [BLOCK_BITS-1:0] blk;
        logic [13:0] imp_head;
        int first_v;
        int run;
        bit found;

        reset      = 1'b0;
        data_valid = 1'b0;
        input_data = 1'b0;
        #1;
        chk("reset_valid_out", 32'(valid_out), 32'd0);
        chk("reset_output_data", 32'(output_data), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(ready_out), 32'd1);

        // All-zero block: latency and a 192-cycle unbroken valid run.
        blk = '0;
        push_model(blk);
        send_block(blk, 0);
        found = 0;
        first_v = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (valid_out) begin
                found = 1;
                first_v = cyc;
            end
        end
        chk("first_valid_latency", 32'(first_v - last_acc_cyc), 32'd2);
        run = found ? 1 : 0;
        for (int i = 0; i < 400 && found; i++) begin
            @(negedge clk);
            if (!valid_out) break;
            run++;
        end
        chk("valid_run_length", 32'(run), 32'(CODED_BITS));
        drain();

        // Impulse at bit 0: known generator response then zeros.
        imp_head = 14'b11100011110111;
        for (int i = 0; i < 14; i++) exp_q.push_back(imp_head[i]);
        for (int i = 14; i < CODED_BITS; i++) exp_q.push_back(1'b0);
        blk = '0;
        blk[0] = 1'b1;
        send_block(blk, 0);
        drain();

        // Tail bits set: start state 111111, and the register must end there too.
        blk = '0;
        blk[95:90] = 6'h3F;
        push_model(blk);
        send_block(blk, 0);
        drain();
        chk("tailbite_end_state", 32'(dut.r_sr), 32'h3F);

        // Three back-to-back blocks at one bit per two cycles.
        for (int b = 0; b < 3; b++) begin
            blk = rand_block();
            push_model(blk);
            send_block(blk, 1);
            chk("wr_bank_alternation", 32'(dut.u_buf.r_wr_sel), 32'(blocks_sent % 2));
            if (b == 0) track_ro = 1;
        end
        track_ro = 0;
        chk("ready_out_gaps", 32'(ro_gaps), 32'd0);
        drain();
        chk("rd_bank_alternation", 32'(dut.u_buf.r_rd_sel), 32'(blocks_sent % 2));

        // Random downstream stalls with a continuously busy writer.
        seen_ro_low = 0;
        rand_rdy = 1;
        for (int b = 0; b < 4; b++) begin
            blk = rand_block();
            push_model(blk);
            send_block(blk, 0);
        end
        drain();
        rand_rdy = 0;
        chk("ready_out_dropped_both_full", 32'(seen_ro_low), 32'd1);

        // Reset in the middle of block 2 input while block 1 is being encoded.
        blk = rand_block();
        push_model(blk);
        send_block(blk, 1);
        blk = rand_block();
        for (int i = 0; i < 40; i++) begin
            send_bit(blk[i]);
            @(posedge clk);
            #1;
        end
        chk("encoding_before_reset", 32'(valid_out), 32'd1);
        data_valid = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("reset_mid_valid_out", 32'(valid_out), 32'd0);
        chk("reset_mid_output_data", 32'(output_data), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        blocks_sent = 0;
        @(posedge clk);
        #1;
        chk("ready_after_mid_reset", 32'(ready_out), 32'd1);
        repeat (300) @(posedge clk);
        #1;
        chk("no_residual_output", 32'(valid_out), 32'd0);
        blk = rand_block();
        push_model(blk);
        send_block(blk, 0);
        drain();
        chk("post_reset_bank", 32'(dut.u_buf.r_wr_sel), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
